// File: rtl/riscy_pkg.sv
// Shared riscy load/store definitions: access size encodings, LSU FSM states and
// small lane helpers used by the LSU and its alignment sub-module.
package riscy_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_RESP = 2'b10
   } lsu_state_e;

   // The reserved encoding 2'b11 behaves exactly like a word access.
   function automatic size_e norm_size(input logic [1:0] raw);
      size_e s;
      case (raw)
         2'b00:   s = SIZE_BYTE;
         2'b01:   s = SIZE_HALF;
         default: s = SIZE_WORD;
      endcase
      return s;
   endfunction

   function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
      logic m;
      case (size)
         SIZE_BYTE: m = 1'b0;
         SIZE_HALF: m = offset[0];
         default:   m = |offset;
      endcase
      return m;
   endfunction

   // Clears the low offset bits a naturally aligned access of this size cannot have.
   function automatic logic [1:0] align_offset(input size_e size, input logic [1:0] offset);
      logic [1:0] o;
      case (size)
         SIZE_BYTE: o = offset;
         SIZE_HALF: o = {offset[1], 1'b0};
         default:   o = 2'b00;
      endcase
      return o;
   endfunction

   function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] offset);
      logic [3:0] m;
      case (size)
         SIZE_BYTE: m = 4'b0001 << offset;
         SIZE_HALF: m = offset[1] ? 4'b1100 : 4'b0011;
         default:   m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and memory bus signals of the LSU, bundled with the
// LSU-side (slave) and environment-side (master) views.
interface lsu_if #(
   parameter int MEM_AW = 14
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_misalign;
   logic              mem_req;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [3:0]        mem_wmask;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_ack, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_misalign,
      output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output mem_ack, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misalign,
      input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational load-lane select and sign/zero extension of a captured memory word.
module lsu_align
   import riscy_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  size_e       size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[7:0];
      case (offset_i)
         2'b00:   byte_sel = word_i[7:0];
         2'b01:   byte_sel = word_i[15:8];
         2'b10:   byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      data_o = word_i;
      case (size_i)
         SIZE_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SIZE_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default:   data_o = word_i;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding core access mapped onto a word-wide memory bus.
// Build option RISCY_MISALIGN_TRAP_EN reports misaligned half/word accesses instead of force-aligning them.
module lsu
   import riscy_pkg::*;
#(
   parameter int MEM_AW = 14
) (
   input  logic clk,
   input  logic reset,
   lsu_if.slave bus
);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   size_e             size_q, size_d;
   logic              uns_q, uns_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              mis_q, mis_d;

   size_e             req_size_n;
   logic [1:0]        req_off_n;
   logic              misalign_req;
   logic [31:0]       load_data;
   logic [31:0]       lane_wdata;
   logic              in_bus;
   logic              in_resp;
   logic              store_bus;
   logic [31:0]       unused_req_addr;

   assign req_size_n      = norm_size(bus.req_size);
   assign req_off_n       = align_offset(req_size_n, bus.req_addr[1:0]);
   assign unused_req_addr = bus.req_addr;

`ifdef RISCY_MISALIGN_TRAP_EN
   assign misalign_req = is_misaligned(req_size_n, bus.req_addr[1:0]);
`else
   assign misalign_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         size_q  <= SIZE_BYTE;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end

   // The access is latched whole at acceptance so the core may change its inputs freely afterwards.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mis_d   = mis_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               size_d  = req_size_n;
               uns_d   = bus.req_unsigned;
               addr_d  = {bus.req_addr[MEM_AW-1:2], req_off_n};
               wdata_d = bus.req_wdata;
               mis_d   = misalign_req;
               state_d = misalign_req ? ST_RESP : ST_BUS;
            end
         end
         ST_BUS: begin
            if (bus.mem_ack) begin
               rdata_d = bus.mem_rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_wdata[8*gi +: 8] = (size_q == SIZE_BYTE) ? wdata_q[7:0] :
                                     (size_q == SIZE_HALF) ? wdata_q[8*(gi%2) +: 8] :
                                                             wdata_q[8*gi +: 8];
   end

   lsu_align u_align (
      .word_i     (rdata_q),
      .offset_i   (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (load_data)
   );

   assign in_bus    = (state_q == ST_BUS);
   assign in_resp   = (state_q == ST_RESP);
   assign store_bus = in_bus & we_q;

   // Bus outputs come only from registered state, so they cannot move during BUS.
   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = in_resp;
   assign bus.rsp_rdata = (in_resp && !we_q && !mis_q) ? load_data : 32'h0;
   assign bus.mem_req   = in_bus;
   assign bus.mem_we    = store_bus;
   assign bus.mem_addr  = in_bus ? {addr_q[MEM_AW-1:2], 2'b00} : '0;
   assign bus.mem_wmask = store_bus ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
   assign bus.mem_wdata = store_bus ? lane_wdata : 32'h0;

`ifdef RISCY_MISALIGN_TRAP_EN
   assign bus.rsp_misalign = in_resp & mis_q;
`else
   assign bus.rsp_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases, randomized accesses against a
// byte-arithmetic reference model, reset abandonment and back-to-back requests.
module tb_lsu;
   localparam int AW = 14;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lsu_if #(.MEM_AW(AW)) bus ();

   lsu #(.MEM_AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic          accepted;
      int            bus_cycles;
      int            rsp_cycles;
      int            lat;
      logic [AW-1:0] maddr;
      logic [3:0]    wmask;
      logic [31:0]   wdata;
      logic          mwe;
      logic          stable;
      logic          ready_ok;
      logic [31:0]   rdata;
      logic          mis;
   } obs_t;

   typedef struct {
      int            bus_cycles;
      int            lat;
      logic [AW-1:0] maddr;
      logic [3:0]    wmask;
      logic [31:0]   wdata;
      logic          mwe;
      logic [31:0]   rdata;
      logic          mis;
   } exp_t;

   // Reference: latency counted with the acceptance cycle as cycle 1.
   function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input int waits, input logic [31:0] rd);
      exp_t e;
      int n;
      longint unsigned ea, off, v, lim;
      e = '{default: 0};
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`ifdef RISCY_MISALIGN_TRAP_EN
      if ((64'(addr) % 64'(n)) != 0) begin
         e.mis = 1'b1;
         e.lat = 2;
         return e;
      end
`endif
      ea  = 64'(addr) - (64'(addr) % 64'(n));
      off = ea % 4;
      e.maddr      = AW'((ea % (64'd1 << AW)) - off);
      e.bus_cycles = waits + 1;
      e.lat        = waits + 3;
      e.mwe        = we;
      if (we) begin
         e.wmask = 4'(((64'd1 << n) - 1) << off);
         e.wdata = (n == 1) ? (wd & 32'hFF) * 32'h01010101 :
                   (n == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      end else begin
         lim = 64'd1 << (8 * n);
         v   = (64'(rd) >> (8 * off)) % lim;
         if (!uns && n < 4 && v >= lim / 2) v = v + (64'd1 << 32) - lim;
         e.rdata = 32'(v);
      end
      return e;
   endfunction

   // Drives one access from IDLE, plays the memory responder and records what the DUT did.
   task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int waits, input logic [31:0] rd, output obs_t o);
      o = '{default: 0};
      o.lat      = -1;
      o.stable   = 1'b1;
      o.ready_ok = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      o.accepted = bus.req_ready;
      @(posedge clk); #1;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
      for (int cyc = 1; cyc <= waits + 6; cyc++) begin
         if (bus.mem_req) begin
            if (o.bus_cycles == 0) begin
               o.maddr = bus.mem_addr;
               o.wmask = bus.mem_wmask;
               o.wdata = bus.mem_wdata;
               o.mwe   = bus.mem_we;
            end else if (o.maddr !== bus.mem_addr || o.wmask !== bus.mem_wmask ||
                         o.wdata !== bus.mem_wdata || o.mwe !== bus.mem_we) begin
               o.stable = 1'b0;
            end
            o.bus_cycles++;
            bus.mem_ack   = (o.bus_cycles == waits + 1);
            bus.mem_rdata = (o.bus_cycles == waits + 1) ? rd : $urandom;
         end else begin
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
         end
         if (bus.rsp_valid) begin
            if (o.rsp_cycles == 0) begin
               o.lat   = cyc + 1;
               o.rdata = bus.rsp_rdata;
               o.mis   = bus.rsp_misalign;
            end
            o.rsp_cycles++;
         end
         if (bus.req_ready === (bus.mem_req || bus.rsp_valid)) o.ready_ok = 1'b0;
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      bus.mem_ack      = 1'b1;
      bus.mem_rdata    = 32'hDEADBEEF;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_misalign, bus.mem_req, bus.mem_we,
           bus.mem_addr, bus.mem_wmask, bus.mem_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got rsp_valid=%b rdata=%h mis=%b mem_req=%b we=%b addr=%h mask=%b wdata=%h exp all zero",
                  bus.rsp_valid, bus.rsp_rdata, bus.rsp_misalign, bus.mem_req, bus.mem_we,
                  bus.mem_addr, bus.mem_wmask, bus.mem_wdata);
      end
      reset       = 1'b0;
      bus.mem_ack = 1'b0;
      @(posedge clk); #1;
      $display("txn reset: req_ready=%b", bus.req_ready);
   endtask

   task automatic test_directed();
      obs_t o;
      // Store byte 0xAB to 0x13 with two wait states.
      run_access(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AB, 2, $urandom, o);
      $display("txn sb 0x13: addr=%h mask=%b wdata=%h bus=%0d lat=%0d", o.maddr, o.wmask, o.wdata, o.bus_cycles, o.lat);
      checks++;
      if (o.maddr !== AW'(14'h10) || o.wmask !== 4'b1000 || o.wdata !== 32'hABABABAB) begin
         failures++;
         $display("FAIL sb_bus got addr=%h mask=%b wdata=%h exp addr=0010 mask=1000 wdata=abababab", o.maddr, o.wmask, o.wdata);
      end
      checks++;
      if (o.bus_cycles !== 3 || o.stable !== 1'b1 || o.lat !== 5 || o.rsp_cycles !== 1) begin
         failures++;
         $display("FAIL sb_timing got bus=%0d stable=%b lat=%0d rsp=%0d exp bus=3 stable=1 lat=5 rsp=1", o.bus_cycles, o.stable, o.lat, o.rsp_cycles);
      end

      // Half loads from 0x22, signed then unsigned.
      run_access(1'b0, 2'b01, 1'b0, 32'h22, $urandom, 0, 32'h80017F00, o);
      $display("txn lh 0x22: rdata=%h lat=%0d", o.rdata, o.lat);
      checks++;
      if (o.rdata !== 32'hFFFF8001 || o.lat !== 3) begin
         failures++;
         $display("FAIL lh_signed got rdata=%h lat=%0d exp rdata=ffff8001 lat=3", o.rdata, o.lat);
      end
      run_access(1'b0, 2'b01, 1'b1, 32'h22, $urandom, 0, 32'h80017F00, o);
      $display("txn lhu 0x22: rdata=%h", o.rdata);
      checks++;
      if (o.rdata !== 32'h00008001 || o.wmask !== 4'b0000) begin
         failures++;
         $display("FAIL lh_unsigned got rdata=%h mask=%b exp rdata=00008001 mask=0000", o.rdata, o.wmask);
      end

      // Signed byte load from 0x01.
      run_access(1'b0, 2'b00, 1'b0, 32'h01, $urandom, 1, 32'h0000FF00, o);
      $display("txn lb 0x01: rdata=%h", o.rdata);
      checks++;
      if (o.rdata !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL lb_signed got rdata=%h exp ffffffff", o.rdata);
      end

      // Misaligned word load from 0x06.
      run_access(1'b0, 2'b10, 1'b0, 32'h06, $urandom, 0, 32'h12345678, o);
      $display("txn lw 0x06: mis=%b bus=%0d rdata=%h lat=%0d", o.mis, o.bus_cycles, o.rdata, o.lat);
`ifdef RISCY_MISALIGN_TRAP_EN
      checks++;
      if (o.mis !== 1'b1 || o.bus_cycles !== 0 || o.rdata !== 32'h0 || o.lat !== 2) begin
         failures++;
         $display("FAIL lw_misalign got mis=%b bus=%0d rdata=%h lat=%0d exp mis=1 bus=0 rdata=0 lat=2", o.mis, o.bus_cycles, o.rdata, o.lat);
      end
`else
      checks++;
      if (o.mis !== 1'b0 || o.maddr !== AW'(14'h04) || o.rdata !== 32'h12345678 || o.lat !== 3) begin
         failures++;
         $display("FAIL lw_forced_align got mis=%b addr=%h rdata=%h lat=%0d exp mis=0 addr=0004 rdata=12345678 lat=3", o.mis, o.maddr, o.rdata, o.lat);
      end
`endif
   endtask

   task automatic test_random();
      obs_t o;
      exp_t e;
      logic we, uns;
      logic [1:0] size;
      logic [31:0] addr, wd, rd;
      int waits;
      for (int i = 0; i < 60; i++) begin
         we    = 1'($urandom);
         size  = 2'($urandom);
         uns   = 1'($urandom);
         addr  = $urandom;
         wd    = $urandom;
         rd    = $urandom;
         waits = $urandom_range(0, 3);
         e = model(we, size, uns, addr, wd, waits, rd);
         run_access(we, size, uns, addr, wd, waits, rd, o);
         $display("txn rand %0d: we=%b size=%0d uns=%b addr=%h waits=%0d -> mis=%b rdata=%h mask=%b wdata=%h",
                  i, we, size, uns, addr, waits, o.mis, o.rdata, o.wmask, o.wdata);
         checks++;
         if (o.accepted !== 1'b1 || o.ready_ok !== 1'b1 || o.rsp_cycles !== 1) begin
            failures++;
            $display("FAIL rand_handshake[%0d] got accepted=%b ready_ok=%b rsp_cycles=%0d exp 1 1 1", i, o.accepted, o.ready_ok, o.rsp_cycles);
         end
         checks++;
         if (o.bus_cycles !== e.bus_cycles || o.lat !== e.lat || o.stable !== 1'b1) begin
            failures++;
            $display("FAIL rand_timing[%0d] got bus=%0d lat=%0d stable=%b exp bus=%0d lat=%0d stable=1", i, o.bus_cycles, o.lat, o.stable, e.bus_cycles, e.lat);
         end
         checks++;
         if (o.rdata !== e.rdata || o.mis !== e.mis) begin
            failures++;
            $display("FAIL rand_rsp[%0d] got rdata=%h mis=%b exp rdata=%h mis=%b", i, o.rdata, o.mis, e.rdata, e.mis);
         end
         if (e.bus_cycles > 0) begin
            checks++;
            if (o.maddr !== e.maddr || o.mwe !== e.mwe || o.wmask !== e.wmask) begin
               failures++;
               $display("FAIL rand_bus[%0d] got addr=%h we=%b mask=%b exp addr=%h we=%b mask=%b", i, o.maddr, o.mwe, o.wmask, e.maddr, e.mwe, e.wmask);
            end
            if (we) begin
               checks++;
               if (o.wdata !== e.wdata) begin
                  failures++;
                  $display("FAIL rand_wdata[%0d] got %h exp %h", i, o.wdata, e.wdata);
               end
            end
         end
      end
   endtask

   task automatic test_reset_midbus();
      logic saw_rsp = 1'b0;
      logic saw_req = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 32'h100;
      bus.req_wdata = 32'h5A5A1234;
      bus.mem_ack   = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1) begin
         failures++;
         $display("FAIL midbus_enter got mem_req=%b exp 1", bus.mem_req);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL midbus_reset got mem_req=%b req_ready=%b exp 0 1", bus.mem_req, bus.req_ready);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = $urandom;
      for (int c = 0; c < 4; c++) begin
         if (bus.rsp_valid) saw_rsp = 1'b1;
         if (bus.mem_req) saw_req = 1'b1;
         @(posedge clk); #1;
         bus.mem_ack = 1'b0;
      end
      $display("txn reset mid-bus: saw_rsp=%b saw_req=%b req_ready=%b", saw_rsp, saw_req, bus.req_ready);
      checks++;
      if (saw_rsp !== 1'b0 || saw_req !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL midbus_late_ack got rsp=%b mem_req=%b req_ready=%b exp 0 0 1", saw_rsp, saw_req, bus.req_ready);
      end
   endtask

   task automatic test_back_to_back();
      int accepts[$];
      logic [31:0] rsps[$];
      int bad_ready = 0;
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h40;
      for (int c = 0; c < 10; c++) begin
         if (bus.req_ready && bus.req_valid) accepts.push_back(c);
         if ((bus.mem_req || bus.rsp_valid) && bus.req_ready) bad_ready++;
         bus.mem_ack   = bus.mem_req;
         bus.mem_rdata = 32'hC3B2A190;
         if (bus.rsp_valid) rsps.push_back(bus.rsp_rdata);
         @(posedge clk); #1;
         if (accepts.size() == 1) begin
            bus.req_size = 2'b00;
            bus.req_addr = 32'h43;
         end else if (accepts.size() == 2) begin
            bus.req_valid = 1'b0;
         end
      end
      bus.mem_ack = 1'b0;
      $display("txn back-to-back: accepts=%0d rsps=%0d bad_ready=%0d", accepts.size(), rsps.size(), bad_ready);
      checks++;
      if (accepts.size() != 2 || rsps.size() != 2 || bad_ready != 0) begin
         failures++;
         $display("FAIL b2b_counts got accepts=%0d rsps=%0d bad_ready=%0d exp 2 2 0", accepts.size(), rsps.size(), bad_ready);
      end else begin
         checks++;
         if (accepts[1] - accepts[0] != 3) begin
            failures++;
            $display("FAIL b2b_gap got %0d exp 3", accepts[1] - accepts[0]);
         end
         checks++;
         if (rsps[0] !== 32'hC3B2A190 || rsps[1] !== 32'hFFFFFFC3) begin
            failures++;
            $display("FAIL b2b_data got %h %h exp c3b2a190 ffffffc3", rsps[0], rsps[1]);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_midbus();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEM_AW, default 14, memory byte-address width driven on mem_addr.
REQ-002 SHALL have ports, clock and reset first (name direction width meaning):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  core access request
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word
- req_unsigned  in  1  zero-extend load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data
- rsp_misalign  out  1  access faulted, qualified by rsp_valid
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  bus write
- mem_addr  out  MEM_AW  word-aligned byte address
- mem_wmask  out  4  byte-lane write enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  responder done; mem_rdata valid same cycle
- mem_rdata  in  32  full read word

Function
REQ-003 SHALL implement FSM IDLE, BUS, RESP; req_ready = 1 only in IDLE.
REQ-004 SHALL, on acceptance in IDLE, register we/size/unsigned/addr/wdata; later input changes have no effect on that access.
REQ-005 SHALL go IDLE->BUS on acceptance; BUS->RESP on mem_ack; RESP->IDLE unconditionally.
REQ-006 SHALL hold mem_req, mem_we, mem_addr, mem_wmask and mem_wdata stable throughout BUS; mem_req = 0 outside BUS.
REQ-007 SHALL drive mem_addr = {addr[MEM_AW-1:2], 2'b00}; upper address bits are ignored.
REQ-008 SHALL drive mem_wmask = 0001<<addr[1:0] for byte, 0011<<{addr[1],0} for half, 1111 for word; 0000 on loads.
REQ-009 SHALL replicate store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-010 SHALL capture mem_rdata on mem_ack and select lane by addr[1:0] (byte) or addr[1] (half), then sign-extend, or zero-extend if req_unsigned.
REQ-011 SHALL assert rsp_valid for exactly the RESP cycle; rsp_rdata = extended load data for loads, 0 for stores.
REQ-012 SHALL treat req_size 11 as word.
REQ-013 SHALL ignore mem_ack outside BUS.
REQ-014 SHALL give a minimum load/store latency of 3 cycles from acceptance to rsp_valid (zero-wait ack); each wait cycle adds one.

Reset
REQ-015 SHALL on reset enter IDLE, with req_ready = 1 and all other outputs 0 on the next cycle.
REQ-016 SHALL, on reset during BUS or RESP, abandon the access: mem_req drops and no rsp_valid is produced.

Configuration
REQ-017 SHALL, with RISCY_MISALIGN_TRAP_EN defined, detect half with addr[0] = 1 or word with addr[1:0] != 0, and go IDLE->RESP with rsp_misalign = 1, rsp_rdata = 0, and no bus cycle.
REQ-018 SHALL, without RISCY_MISALIGN_TRAP_EN, tie rsp_misalign to 0 and silently force natural alignment by ignoring the offending low address bits.

Structure
REQ-019 SHALL take the size encodings BYTE/HALF/WORD and the FSM state enum from shared package riscy_pkg.
REQ-020 SHALL put lane select and extension in combinational sub-module lsu_align.

Verification
REQ-021 Store byte 0xAB to addr 0x13, ack after 2 waits -> mem_addr 0x10, mem_wmask 1000, mem_wdata 0xABABABAB held for 3 BUS cycles, rsp_valid 1 cycle later.
REQ-022 Load half addr 0x22 with mem_rdata 0x80017F00, signed -> rsp_rdata 0xFFFF8001; with req_unsigned -> 0x00008001.
REQ-023 Load byte addr 0x01 with mem_rdata 0x0000FF00, signed -> rsp_rdata 0xFFFFFFFF.
REQ-024 Word load at addr 0x06 with macro -> rsp_misalign 1 two cycles after acceptance, mem_req never high; without macro -> word read from 0x04.
REQ-025 Reset asserted in BUS before ack, then late mem_ack -> mem_req 0, no rsp_valid, req_ready 1.
REQ-026 req_valid held high with back-to-back requests -> a second request is accepted only after RESP; req_ready low in BUS and RESP.
